// File: rtl/spi_keycode_responder.sv
// spi_keycode_responder: mode-0 SPI responder that writes keycode/difficulty and reads back a score snapshot
module spi_keycode_responder #(
  parameter logic [7:0] ID_BYTE = 8'hA5,
  parameter int SCORE_W = 12
) (
  input  logic               Clk,
  input  logic               Reset_n,
  input  logic               spi_sclk,
  input  logic               spi_cs_n,
  input  logic               spi_mosi,
  output logic               spi_miso,
  output logic               spi_miso_oe,
  input  logic [SCORE_W-1:0] Score,
  output logic [7:0]         keycode,
  output logic               keycode_strobe,
  output logic [1:0]         difficulty,
  output logic               abort_pulse
);
  typedef enum logic [2:0] {WAIT_IDLE, IDLE, CMD, DATA, EXEC, DRAIN} state_t;
  state_t state;
  logic [2:0] sclk_s, cs_s;
  logic [1:0] mosi_s;
  logic [2:0] cnt;
  logic [6:0] sh_in;
  logic [7:0] shreg, cmd, data, byte_nx, resp;
  logic [SCORE_W-1:0] snap;
  logic [15:0] snap_ext;
  logic sclk_rise, sclk_fall, cs_rise, cs_fall, in_xfer;
  // Two synchroniser flops per pin plus a third stage for edge detection; cleared so a reset under CS_n low is never seen as a fresh CS_n fall
  always_ff @(posedge Clk or negedge Reset_n)
    if (!Reset_n) begin
      sclk_s <= '0;
      cs_s   <= '0;
      mosi_s <= '0;
    end else begin
      sclk_s <= {sclk_s[1:0], spi_sclk};
      cs_s   <= {cs_s[1:0], spi_cs_n};
      mosi_s <= {mosi_s[0], spi_mosi};
    end
  // Edge events, the byte completed by the current rise, and the byte-1 reply selected by that command byte
  always_comb begin
    sclk_rise = sclk_s[1] & ~sclk_s[2];
    sclk_fall = ~sclk_s[1] & sclk_s[2];
    cs_rise   = cs_s[1] & ~cs_s[2];
    cs_fall   = ~cs_s[1] & cs_s[2];
    in_xfer   = state == CMD || state == DATA || state == DRAIN;
    byte_nx   = {sh_in, mosi_s[1]};
    snap_ext  = 16'(snap);
    resp      = byte_nx == 8'h03 ? snap_ext[15:8] : byte_nx == 8'h04 ? snap_ext[7:0] : 8'h00;
  end
  // Transaction FSM: shifts bits in on SCLK rise, out on SCLK fall, executes the command one Clk after the 16th rise
  always_ff @(posedge Clk or negedge Reset_n)
    if (!Reset_n) begin
      state          <= WAIT_IDLE;
      cnt            <= '0;
      sh_in          <= '0;
      shreg          <= '0;
      cmd            <= '0;
      data           <= '0;
      snap           <= '0;
      spi_miso       <= 1'b0;
      spi_miso_oe    <= 1'b0;
      keycode        <= '0;
      keycode_strobe <= 1'b0;
      difficulty     <= '0;
      abort_pulse    <= 1'b0;
    end else begin
      keycode_strobe <= 1'b0;
      abort_pulse    <= 1'b0;
      if (in_xfer && cs_rise) begin
        state       <= IDLE;
        spi_miso    <= 1'b0;
        spi_miso_oe <= 1'b0;
        abort_pulse <= cnt != 3'd0;
        cnt         <= '0;
      end else
        case (state)
          WAIT_IDLE: if (cs_s[1]) state <= IDLE;
          IDLE: if (cs_fall) begin
            snap        <= Score;
            shreg       <= {ID_BYTE[6:0], 1'b0};
            spi_miso    <= ID_BYTE[7];
            spi_miso_oe <= 1'b1;
            cnt         <= '0;
            state       <= CMD;
          end
          EXEC: begin
            if (cmd == 8'h01) begin
              keycode        <= data;
              keycode_strobe <= 1'b1;
            end
            if (cmd == 8'h02) difficulty <= data[1:0];
            state <= cs_rise ? IDLE : DRAIN;
            if (cs_rise) begin
              spi_miso    <= 1'b0;
              spi_miso_oe <= 1'b0;
            end
          end
          default: if (sclk_rise) begin
            cnt   <= cnt + 3'd1;
            sh_in <= byte_nx[6:0];
            if (cnt == 3'd7 && state == CMD) begin
              cmd   <= byte_nx;
              shreg <= resp;
              state <= DATA;
            end
            if (cnt == 3'd7 && state == DATA) begin
              data  <= byte_nx;
              shreg <= '0;
              state <= EXEC;
            end
          end else if (sclk_fall) begin
            spi_miso <= shreg[7];
            shreg    <= {shreg[6:0], 1'b0};
          end
        endcase
    end
endmodule

// File: tb/tb_spi_keycode_responder.sv
// tb_spi_keycode_responder: directed SPI transactions with a scoreboard of expected MISO bytes
module tb_spi_keycode_responder;
  logic Clk = 0, Reset_n = 0, spi_sclk = 0, spi_cs_n = 1, spi_mosi = 0;
  logic spi_miso, spi_miso_oe, keycode_strobe, abort_pulse;
  logic [11:0] Score = '0;
  logic [7:0] keycode;
  logic [1:0] difficulty;
  logic [7:0] q[$];
  int checks = 0, errors = 0, n_str = 0, n_ab = 0, s0, a0;

  spi_keycode_responder dut (
    .Clk(Clk), .Reset_n(Reset_n), .spi_sclk(spi_sclk), .spi_cs_n(spi_cs_n), .spi_mosi(spi_mosi),
    .spi_miso(spi_miso), .spi_miso_oe(spi_miso_oe), .Score(Score), .keycode(keycode),
    .keycode_strobe(keycode_strobe), .difficulty(difficulty), .abort_pulse(abort_pulse));

  always #10 Clk = ~Clk;

  always @(posedge Clk) begin
    if (keycode_strobe) n_str++;
    if (abort_pulse) n_ab++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic xfer(input logic [7:0] b0, input logic [7:0] b1, input int nbits, input bit fast,
                      input int chg_bit, input logic [11:0] chg_val);
    logic [15:0] tx, rx;
    tx = {b0, b1};
    rx = '0;
    spi_cs_n = 0;
    for (int i = 0; i < nbits; i++) begin
      if (i == chg_bit) Score = chg_val;
      spi_mosi = tx[15-i];
      repeat (5) @(negedge Clk);
      rx[15-i] = spi_miso;
      if (i == 0) chk("oe_active", spi_miso_oe, 1);
      spi_sclk = 1;
      if (fast && i == nbits - 1) begin
        @(negedge Clk);
        spi_cs_n = 1;
      end
      repeat (5) @(negedge Clk);
      spi_sclk = 0;
    end
    repeat (5) @(negedge Clk);
    spi_cs_n = 1;
    repeat (6) @(negedge Clk);
    chk("oe_idle", spi_miso_oe, 0);
    if (nbits == 16) begin
      if (q.size() < 2) chk("queue_underflow", q.size(), 2);
      else begin
        chk("miso_byte0", rx[15:8], q.pop_front());
        chk("miso_byte1", rx[7:0], q.pop_front());
      end
    end
  endtask

  initial begin
    repeat (3) @(negedge Clk);
    Reset_n = 1;
    repeat (5) @(negedge Clk);
    chk("rst_keycode", keycode, 0);
    chk("rst_diff", difficulty, 0);
    chk("rst_strobe", n_str, 0);
    chk("rst_abort", n_ab, 0);
    chk("rst_miso", spi_miso, 0);
    chk("rst_oe", spi_miso_oe, 0);

    q.push_back(8'hA5); q.push_back(8'h00);
    xfer(8'h01, 8'h1A, 16, 0, -1, '0);
    chk("key_1a", keycode, 8'h1A);
    chk("strobe_1", n_str, 1);
    chk("diff_unchanged", difficulty, 0);

    Score = 12'h3C7;
    q.push_back(8'hA5); q.push_back(8'h03);
    xfer(8'h03, 8'h00, 16, 0, -1, '0);
    q.push_back(8'hA5); q.push_back(8'hC7);
    xfer(8'h04, 8'h00, 16, 0, 10, 12'h000);
    q.push_back(8'hA5); q.push_back(8'h00);
    xfer(8'h04, 8'h00, 16, 0, -1, '0);
    chk("read_no_write", keycode, 8'h1A);

    q.push_back(8'hA5); q.push_back(8'h00);
    xfer(8'h02, 8'hFE, 16, 0, -1, '0);
    chk("diff_2", difficulty, 2'b10);
    chk("diff_no_strobe", n_str, 1);
    q.push_back(8'hA5); q.push_back(8'h00);
    xfer(8'h7F, 8'h55, 16, 0, -1, '0);
    chk("unk_key", keycode, 8'h1A);
    chk("unk_diff", difficulty, 2'b10);
    chk("unk_strobe", n_str, 1);

    xfer(8'h01, 8'h80, 11, 0, -1, '0);
    chk("abort_1", n_ab, 1);
    chk("abort_key", keycode, 8'h1A);
    chk("abort_strobe", n_str, 1);
    q.push_back(8'hA5); q.push_back(8'h00);
    xfer(8'h01, 8'h26, 16, 0, -1, '0);
    chk("key_26", keycode, 8'h26);
    chk("strobe_2", n_str, 2);

    q.push_back(8'hA5); q.push_back(8'h00);
    xfer(8'h01, 8'h3C, 16, 1, -1, '0);
    chk("fast_key", keycode, 8'h3C);
    chk("fast_no_abort", n_ab, 1);
    chk("fast_strobe", n_str, 3);

    s0 = n_str;
    a0 = n_ab;
    spi_cs_n = 0;
    for (int i = 0; i < 5; i++) begin
      spi_mosi = i[0];
      repeat (5) @(negedge Clk);
      spi_sclk = 1;
      repeat (5) @(negedge Clk);
      spi_sclk = 0;
    end
    Reset_n = 0;
    repeat (3) @(negedge Clk);
    Reset_n = 1;
    for (int i = 0; i < 8; i++) begin
      spi_mosi = 1;
      repeat (5) @(negedge Clk);
      spi_sclk = 1;
      repeat (5) @(negedge Clk);
      spi_sclk = 0;
    end
    chk("rstmid_oe", spi_miso_oe, 0);
    chk("rstmid_key", keycode, 0);
    repeat (5) @(negedge Clk);
    spi_cs_n = 1;
    repeat (6) @(negedge Clk);
    chk("rstmid_strobe", n_str, s0);
    chk("rstmid_abort", n_ab, a0);
    q.push_back(8'hA5); q.push_back(8'h00);
    xfer(8'h01, 8'h07, 16, 0, -1, '0);
    chk("key_07", keycode, 8'h07);
    chk("queue_empty", q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
